// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of entries for a given address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy counter width: one extra bit so DEPTH itself is representable.
  function automatic int fifo_count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  clear;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, w_en, w_data, r_en,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, w_en, w_data, r_en,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO: pointers, occupancy counter, status/error flags and a
// selectable registered or first-word-fall-through read stage.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic            clk,
  input  logic            resetn,
  sync_fifo_ram_if.slave  bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = fifo_count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Flags decode the registered count, so they follow it by one edge.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_ok   = bus.r_en & ~empty;
  assign wr_ok   = bus.w_en & (~full | rd_ok);
  assign rd_fire = rd_ok & ~bus.clear;
  assign wr_fire = wr_ok & ~bus.clear;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.w_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  // Pointer, occupancy and sticky error bookkeeping; clear outranks traffic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.w_en && full && !rd_ok) overflow_q  <= 1'b1;
      if (bus.r_en && empty)          underflow_q <= 1'b1;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry is presented directly from storage whenever one exists.
    assign bus.r_data  = mem_rd;
    assign bus.r_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // Capture the head on an accepted read; r_data keeps its last value otherwise.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (bus.clear) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_fire;
        if (rd_fire) r_data_q <= mem_rd;
      end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed plus short random bench for sync_fifo_ram; a registered-mode and an
// FWFT-mode instance see identical stimulus and are checked against a queue model.
module tb_sync_fifo_ram;

  logic clk;
  logic resetn;

  int total;
  int bad;

  sync_fifo_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_reg ();
  sync_fifo_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_fw ();

  assign bus_fw.clear  = bus_reg.clear;
  assign bus_fw.w_en   = bus_reg.w_en;
  assign bus_fw.w_data = bus_reg.w_data;
  assign bus_fw.r_en   = bus_reg.r_en;

  sync_fifo_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)
  ) dut_reg (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_reg)
  );

  sync_fifo_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)
  ) dut_fw (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [7:0] q[$];
  logic [7:0] last_rd;
  logic       m_rv;
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("count",        32'(bus_reg.count),        32'(n));
    chk("count_fw",     32'(bus_fw.count),         32'(n));
    chk("full",         32'(bus_reg.full),         32'(n == 4));
    chk("empty",        32'(bus_reg.empty),        32'(n == 0));
    chk("almost_full",  32'(bus_reg.almost_full),  32'(n >= 3));
    chk("almost_empty", 32'(bus_reg.almost_empty), 32'(n <= 1));
    chk("full_fw",      32'(bus_fw.full),          32'(n == 4));
    chk("empty_fw",     32'(bus_fw.empty),         32'(n == 0));
    chk("overflow",     32'(bus_reg.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus_reg.underflow),    32'(m_unf));
    chk("overflow_fw",  32'(bus_fw.overflow),      32'(m_ovf));
    chk("underflow_fw", 32'(bus_fw.underflow),     32'(m_unf));
    chk("r_valid",      32'(bus_reg.r_valid),      32'(m_rv));
    chk("r_data",       32'(bus_reg.r_data),       32'(last_rd));
    chk("r_valid_fw",   32'(bus_fw.r_valid),       32'(n != 0));
    if (n != 0) chk("r_data_fw", 32'(bus_fw.r_data), 32'(q[0]));
  endtask

  // One clock of stimulus: update the model from pre-edge state, then check after the edge.
  task automatic step(input logic c, input logic we, input logic [7:0] wd, input logic re);
    logic m_rd;
    logic m_wr;
    bus_reg.clear  = c;
    bus_reg.w_en   = we;
    bus_reg.w_data = wd;
    bus_reg.r_en   = re;
    m_rd = re && (q.size() != 0) && !c;
    m_wr = we && ((q.size() < 4) || m_rd) && !c;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      if (we && q.size() == 4 && !m_rd) m_ovf = 1'b1;
      if (re && q.size() == 0)          m_unf = 1'b1;
      m_rv = m_rd;
      if (m_rd) last_rd = q.pop_front();
      if (m_wr) q.push_back(wd);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic reset_model();
    q.delete();
    last_rd = 8'h00;
    m_rv    = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus_reg.clear  = 1'b0;
    bus_reg.w_en   = 1'b0;
    bus_reg.w_data = 8'h00;
    bus_reg.r_en   = 1'b0;
    resetn = 1'b0;
    reset_model();

    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_state();
    resetn = 1'b1;
    step(0, 0, 8'h00, 0);

    // 2. fill to full, then drain; registered data trails r_en by one cycle
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // 3. write while full is dropped and sets overflow
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 0);
    step(0, 1, 8'h55, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

    // 4. clear the sticky flag, then simultaneous write+read while full
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 1, 8'h44, 0);
    step(0, 1, 8'h66, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // 5. simultaneous write+read while empty: read rejected, write kept
    step(0, 1, 8'h77, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // 6. count=3 with overflow set, then clear beats a concurrent write
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h04, 0);
    step(0, 1, 8'h05, 0);
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'h99, 0);
    step(0, 0, 8'h00, 0);

    // mid-burst asynchronous reset, checked between clock edges
    step(0, 1, 8'hA1, 0);
    step(0, 1, 8'hA2, 1);
    step(0, 1, 8'hA3, 0);
    #2;
    resetn = 1'b0;
    bus_reg.w_en = 1'b0;
    bus_reg.r_en = 1'b0;
    reset_model();
    #1;
    check_state();
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // short random mix
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ram.md
Name: sync_fifo_ram

Overview:
- Single-clock, parametrised FIFO buffer for pipelined-CPU inter-stage queues; successor to the dual-port FIFO storage array.
- Integrates pointers, occupancy counter, full/empty and almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Has a synchronous flush.
- Selectable read mode: registered (1-cycle latency) or first-word-fall-through (FWFT).

Parameters:
- DATA_WIDTH, 32, width of each entry in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 entries).
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- w_en  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- r_en  in  1  read request (registered mode) / pop (FWFT mode).
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  r_data holds a valid entry.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
Reset (resetn low, asynchronous):
- wr_ptr, rd_ptr and count go to 0.
- empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>0).
- r_data=0, r_valid=0, overflow=0, underflow=0.
- Storage array is not reset.

Pointers:
- ADDR_WIDTH bits; increment modulo DEPTH (natural wrap from DEPTH-1 to 0).

Write and read acceptance:
- wr_ok = w_en & (!full | rd_ok).
- rd_ok = r_en & !empty.
- Write accepted: mem[wr_ptr] <= w_data, wr_ptr++.
- Read accepted: rd_ptr++.

Count update:
- +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are combinational decodes of registered count; they update the cycle after the edge that changes count.

Simultaneous events:
- Full + w_en + r_en: both accepted, count stays DEPTH, no overflow.
- Empty + w_en + r_en: write accepted, read rejected, underflow set, count becomes 1.

Errors:
- w_en & full & !rd_ok: data dropped, overflow <= 1.
- r_en & empty: underflow <= 1.
- Both flags are sticky until clear or reset.

Registered mode (FWFT=0):
- On accepted read, r_data <= mem[rd_ptr] and r_valid <= 1 on the same edge, so data is visible the cycle after r_en.
- Otherwise r_valid <= 0 and r_data holds its last value.

FWFT mode (FWFT=1):
- r_data = mem[rd_ptr] combinationally; r_valid = !empty.
- r_en acknowledges the head entry; the next entry appears the following cycle.
- A write into an empty FIFO is visible on r_data one cycle after the write edge.

clear:
- Highest synchronous priority.
- Pointers, count, overflow, underflow and r_valid go to 0; r_data holds.
- w_en and r_en are ignored that cycle.

Mid-operation reset:
- All in-flight state is discarded immediately.
- First write after release lands at address 0.

Decomposition:
- Package fifo_pkg: DEPTH derivation helper (count width = ADDR_WIDTH+1) and a read-mode constant pair FIFO_MODE_REG=0 / FIFO_MODE_FWFT=1.
- Sub-module fifo_mem: single-clock register-array storage, with a synchronous write port and an asynchronous read port addressed by rd_ptr.
- sync_fifo_ram contains the pointers, counter, flags and the read-mode output stage.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3, AE_THRESH=1):
1. Reset then idle -> empty=1, almost_empty=1, full=0, count=0, r_valid=0, r_data=0x00.
2. FWFT=0: write 0x11,0x22,0x33,0x44 on 4 cycles -> count 1,2,3,4; almost_empty drops after count=2; almost_full at 3; full at 4. Then r_en for 4 cycles -> r_data 0x11..0x44, each one cycle after its r_en; empty after the 4th read.
3. Full (count=4): w_en=1 with 0x55, r_en=0 -> overflow=1, count=4. Drain all 4 -> data 0x11..0x44 (0x55 absent).
4. Full: w_en=1 (0x66) and r_en=1 same cycle -> count stays 4, no overflow. Data sequence after draining continues and ends with 0x66, confirming pointer wrap past address 3.
5. Empty: w_en=1 (0x77) and r_en=1 same cycle -> underflow=1, count=1. FWFT=1 build: r_data=0x77, r_valid=1 the next cycle; r_en -> empty=1, r_valid=0.
6. count=3 with overflow=1: pulse clear together with w_en -> count=0, empty=1, overflow=0, write ignored. Assert resetn low mid-burst -> all outputs at reset values immediately, without waiting for a clk edge.
